mem_sram_ctrl: RTL and testbench

MEM-stage SRAM controller for the 5-stage MIPS pipeline. Sits directly after the EXE/MEM pipeline register. It consumes that register's memory-enable, address (ALU result) and store-data outputs and performs each 32-bit access as two 16-bit transactions on the external SRAM. It raises `superStall` to freeze the pipeline until the access completes. This is the responder end of the EXE/MEM memory interface; `superStall` is the signal the pipeline registers hold on.

---
 rtl/mem_sram_pkg.sv | 15 +
 rtl/mem_sram_ctrl.sv | 110 +++++++++++
 tb/tb_mem_sram_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage : mem_sram_pkg

// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: each 32-bit load/store becomes two 16-bit SRAM
// half-accesses while superStall freezes the pipeline.
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_En,
    input  logic                   MEM_W_En,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   superStall,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_dq_i,
    output logic [SRAM_DATA_W-1:0] sram_dq_o,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [3:0]               r_cnt;
    logic                     r_is_wr;
    logic [SRAM_ADDR_W-2:0]   r_word_idx;
    logic [31:0]              r_wdata;
    logic [31:0]              r_rdata;

    logic                     w_req;
    logic                     w_start;
    logic                     w_phase_end;
    logic                     w_active;
    logic                     w_high;
    logic [SRAM_ADDR_W-2:0]   w_word_idx;

    assign w_req       = MEM_R_En | MEM_W_En;
    assign w_start     = (r_state == ST_IDLE) && w_req;
    assign w_phase_end = (r_cnt == LAST_CNT);
    assign w_high      = (r_state == ST_HIGH);
    assign w_active    = (r_state == ST_LOW) || w_high;
    assign w_word_idx  = (SRAM_ADDR_W-1)'((address - BASE_ADDR) >> 2);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req)       w_next = ST_LOW;
            ST_LOW:  if (w_phase_end) w_next = ST_HIGH;
            ST_HIGH: if (w_phase_end) w_next = ST_DONE;
            ST_DONE:                  w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= '0;
            else if (w_active)     r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr    <= 1'b0;
            r_word_idx <= '0;
            r_wdata    <= '0;
        end else if (w_start) begin
            r_is_wr    <= MEM_W_En;
            r_word_idx <= w_word_idx;
            r_wdata    <= writeData;
        end
    end

    // Each half lands on the final cycle of its phase, when the SRAM data has settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_active && !r_is_wr && w_phase_end) begin
            if (w_high) r_rdata[31:16] <= sram_dq_i;
            else        r_rdata[15:0]  <= sram_dq_i;
        end
    end

    assign readData   = r_rdata;
    assign superStall = rst & (w_start | w_active);

    assign sram_addr  = w_active ? {r_word_idx, w_high} : '0;
    assign sram_ce_n  = ~w_active;
    assign sram_oe_n  = ~(w_active & ~r_is_wr);
    assign sram_we_n  = ~(w_active &  r_is_wr);
    assign sram_dq_oe =   w_active &  r_is_wr;
    assign sram_dq_o  = sram_dq_oe ? (w_high ? r_wdata[31:16] : r_wdata[15:0]) : '0;
    assign sram_ub_n  = 1'b0;
    assign sram_lb_n  = 1'b0;

endmodule : mem_sram_ctrl

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: behavioural SRAM plus a read-result scoreboard.
module tb_mem_sram_ctrl;

    localparam int unsigned W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        super_stall;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sram_mem [0:63];
    logic [31:0] word_model [0:15];
    logic [31:0] model_rd = '0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_En   (mem_r_en),
        .MEM_W_En   (mem_w_en),
        .address    (address),
        .writeData  (write_data),
        .readData   (read_data),
        .superStall (super_stall),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    // Asynchronous-read SRAM; writes commit on the clock edge.
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            sram_mem[sram_addr[5:0]] <= sram_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          stall_cyc = 0;
        int          oe_cyc = 0;
        int          we_cyc = 0;
        bit          seen = 0;
        bit          done = 0;
        logic [17:0] a_lo = '0;
        logic [17:0] a_hi = '0;
        logic [31:0] exp;
        logic [16:0] idx;
        idx = 17'((a - BASE) >> 2);

        @(posedge clk); #1;
        mem_w_en = w; mem_r_en = r; address = a; write_data = d;
        if (w) begin
            word_model[idx[3:0]] = d;
            exp = model_rd;
        end else begin
            exp = word_model[idx[3:0]];
            model_rd = exp;
        end
        sb_q.push_back(exp);

        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!sram_ce_n) begin
                if (!seen) a_lo = sram_addr;
                seen = 1;
                a_hi = sram_addr;
            end
            if (!sram_oe_n) oe_cyc++;
            if (!sram_we_n) we_cyc++;
            if (super_stall) stall_cyc++;
            else done = 1;
        end
        if (!done) check({tag, "_timeout"}, 32'(stall_cyc), 32'(2*W+1));

        check({tag, "_stall_cycles"}, 32'(stall_cyc), 32'(2*W+1));
        check({tag, "_readData"}, read_data, sb_q.pop_front());
        check({tag, "_oe_cycles"}, 32'(oe_cyc), w ? 32'd0 : 32'(2*W));
        check({tag, "_we_cycles"}, 32'(we_cyc), w ? 32'(2*W) : 32'd0);
        check({tag, "_addr_low"},  32'(a_lo), 32'({idx, 1'b0}));
        check({tag, "_addr_high"}, 32'(a_hi), 32'({idx, 1'b1}));
    endtask

    task automatic idle(input string tag);
        @(posedge clk); #1;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
        @(negedge clk);
        check({tag, "_idle_stall"}, 32'(super_stall), 32'd0);
        check({tag, "_idle_ce_n"},  32'(sram_ce_n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) word_model[i] = 32'h0;

        // Enables high during reset must not raise the stall.
        mem_r_en = 1'b1; mem_w_en = 1'b1; address = BASE;
        repeat (2) @(negedge clk);
        check("rst_stall",   32'(super_stall), 32'd0);
        check("rst_ce_n",    32'(sram_ce_n), 32'd1);
        check("rst_we_n",    32'(sram_we_n), 32'd1);
        check("rst_oe_n",    32'(sram_oe_n), 32'd1);
        check("rst_dq_oe",   32'(sram_dq_oe), 32'd0);
        check("rst_readData", read_data, 32'h0);
        check("rst_addr",    32'(sram_addr), 32'd0);
        check("rst_ublb",    32'({sram_ub_n, sram_lb_n}), 32'd0);
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        rst = 1'b1;
        idle("post_rst");

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "st0");
        idle("st0");
        check("st0_mem_half0", 32'(sram_mem[0]), 32'h0000BEEF);
        check("st0_mem_half1", 32'(sram_mem[1]), 32'h0000DEAD);

        access(1'b0, 1'b1, 32'd1024, 32'h0, "ld0");
        idle("ld0");

        access(1'b1, 1'b0, 32'd1028, 32'h12345678, "st1");
        access(1'b0, 1'b1, 32'd1028, 32'h0, "ld1");
        idle("b2b");
        check("st1_mem_half0", 32'(sram_mem[2]), 32'h00005678);
        check("st1_mem_half1", 32'(sram_mem[3]), 32'h00001234);

        access(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, "both");
        idle("both");
        check("both_mem_half0", 32'(sram_mem[4]), 32'h0000A5A5);
        check("both_mem_half1", 32'(sram_mem[5]), 32'h0000A5A5);
        access(1'b0, 1'b1, 32'd1032, 32'h0, "ld_both");

        // Read from 1024, then pull reset a little into the HIGH phase.
        @(posedge clk); #1;
        mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'd1024;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_rst_stall",    32'(super_stall), 32'd0);
        check("mid_rst_ce_n",     32'(sram_ce_n), 32'd1);
        check("mid_rst_oe_n",     32'(sram_oe_n), 32'd1);
        check("mid_rst_addr",     32'(sram_addr), 32'd0);
        check("mid_rst_readData", read_data, 32'h0);
        model_rd = 32'h0;
        mem_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        access(1'b0, 1'b1, 32'd1024, 32'h0, "ld_after_rst");
        idle("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_sram_ctrl
